// File: rtl/aibcr3aux_osc_sync_pkg.sv
// Shared constants and helpers for the AUX oscillator/control synchroniser bank.
// The elaboration-time range check macro is defined alongside the package.
`ifndef AIBCR3AUX_OSC_SYNC_PKG_SV
`define AIBCR3AUX_OSC_SYNC_PKG_SV

package aibcr3aux_osc_sync_pkg;

  localparam int MIN_WIDTH    = 1;
  localparam int MAX_WIDTH    = 32;
  localparam int MIN_STAGES   = 2;
  localparam int MAX_STAGES   = 4;
  localparam int MAX_FILT_CNT = 255;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`define AIBCR3AUX_OSC_SYNC_CHECK(label, cond, msg) if (!(cond)) begin : label $error(msg); end

`endif

// File: rtl/aibcr3aux_osc_sync_chan.sv
// One synchroniser channel: scan-stitched sync chain, stability filter and
// rise/fall edge detection on the filtered level.
module aibcr3aux_osc_sync_chan
  import aibcr3aux_osc_sync_pkg::*;
#(
  parameter int   STAGES   = 3,
  parameter int   FILT_CNT = 4,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic CP,
  input  logic CD,
  input  logic D,
  input  logic se_n,
  input  logic si,
  output logic so,
  output logic Q,
  output logic QF,
  output logic RISE,
  output logic FALL
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;
  logic              qf_d_reg;

  // Stage 0 takes D or scan-in; every later stage shifts from its neighbour
  // in both modes, which is what makes the chain scannable.
  assign sync_next[0] = se_n ? D : si;
  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      sync_reg <= {STAGES{RST_VAL}};
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign Q  = sync_reg[STAGES-1];
  assign so = sync_reg[STAGES-1];

  generate
    if (FILT_CNT > 0) begin : g_filt
      localparam int             CW       = clog2(FILT_CNT + 1);
      localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CNT - 1);

      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          qf_reg;
      logic          qf_next;

      // Filter state is frozen while shifting so scan does not disturb it.
      always_comb begin
        cnt_next = cnt_reg;
        qf_next  = qf_reg;
        if (se_n) begin
          if (Q == qf_reg) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_LAST) begin
            qf_next  = Q;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge CP or posedge CD) begin
        if (CD) begin
          cnt_reg <= '0;
          qf_reg  <= RST_VAL;
        end else begin
          cnt_reg <= cnt_next;
          qf_reg  <= qf_next;
        end
      end

      assign QF = qf_reg;
    end else begin : g_bypass
      assign QF = Q;
    end
  endgenerate

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      qf_d_reg <= RST_VAL;
    end else if (se_n) begin
      qf_d_reg <= QF;
    end
  end

  assign RISE = se_n &  QF & ~qf_d_reg;
  assign FALL = se_n & ~QF &  qf_d_reg;

endmodule

// File: rtl/aibcr3aux_osc_sync_bank.sv
// Multi-channel synchroniser bank for asynchronous AUX status inputs; all
// channel sync flops form a single scan chain from si to so.
module aibcr3aux_osc_sync_bank
  import aibcr3aux_osc_sync_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               STAGES   = 3,
  parameter int               FILT_CNT = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [WIDTH-1:0] D,
  input  logic             se_n,
  input  logic             si,
  output logic             so,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QF,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  `AIBCR3AUX_OSC_SYNC_CHECK(g_chk_width,  (WIDTH >= MIN_WIDTH) && (WIDTH <= MAX_WIDTH),     "WIDTH out of range")
  `AIBCR3AUX_OSC_SYNC_CHECK(g_chk_stages, (STAGES >= MIN_STAGES) && (STAGES <= MAX_STAGES), "STAGES out of range")
  `AIBCR3AUX_OSC_SYNC_CHECK(g_chk_filt,   (FILT_CNT >= 0) && (FILT_CNT <= MAX_FILT_CNT),    "FILT_CNT out of range")

  logic [WIDTH:0] scan_link;

  assign scan_link[0] = si;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      aibcr3aux_osc_sync_chan #(
        .STAGES   (STAGES),
        .FILT_CNT (FILT_CNT),
        .RST_VAL  (RST_VAL[gi])
      ) u_chan (
        .CP   (CP),
        .CD   (CD),
        .D    (D[gi]),
        .se_n (se_n),
        .si   (scan_link[gi]),
        .so   (scan_link[gi+1]),
        .Q    (Q[gi]),
        .QF   (QF[gi]),
        .RISE (RISE[gi]),
        .FALL (FALL[gi])
      );
    end
  endgenerate

  assign so = scan_link[WIDTH];

endmodule

// File: tb/tb_aibcr3aux_osc_sync_bank.sv
// Bench for the synchroniser bank: a filtered instance and a bypassed instance
// driven in parallel and compared each cycle against a behavioural model.
module tb_aibcr3aux_osc_sync_bank;

  localparam int             W   = 4;
  localparam logic [W-1:0]   RV1 = 4'b0101;

  logic         CP = 1'b0;
  logic         CD = 1'b1;
  logic         se_n = 1'b1;
  logic         si = 1'b0;
  logic [W-1:0] D = '0;

  logic         so0, so1;
  logic [W-1:0] q0, qf0, r0, f0;
  logic [W-1:0] q1, qf1, r1, f1;

  aibcr3aux_osc_sync_bank #(.WIDTH(W), .STAGES(3), .FILT_CNT(4), .RST_VAL(4'b0000)) dut (
    .CP(CP), .CD(CD), .D(D), .se_n(se_n), .si(si), .so(so0),
    .Q(q0), .QF(qf0), .RISE(r0), .FALL(f0)
  );

  aibcr3aux_osc_sync_bank #(.WIDTH(W), .STAGES(2), .FILT_CNT(0), .RST_VAL(RV1)) dut_byp (
    .CP(CP), .CD(CD), .D(D), .se_n(se_n), .si(si), .so(so1),
    .Q(q1), .QF(qf1), .RISE(r1), .FALL(f1)
  );

  always #5 CP = ~CP;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int stg(input int c);
    return (c == 0) ? 3 : 2;
  endfunction
  function automatic int flt(input int c);
    return (c == 0) ? 4 : 0;
  endfunction
  function automatic logic [W-1:0] rstv(input int c);
    return (c == 0) ? 4'b0000 : RV1;
  endfunction

  // Flat scan-order chain: index i*S+k is channel i stage k.
  bit m_chain [2][16];
  bit m_qf    [2][W];
  int m_run   [2][W];
  bit m_qfd   [2][W];

  function automatic bit m_q(input int c, input int i);
    return m_chain[c][i*stg(c) + stg(c) - 1];
  endfunction
  function automatic bit m_qfo(input int c, input int i);
    return (flt(c) > 0) ? m_qf[c][i] : m_q(c, i);
  endfunction

  task automatic m_reset();
    logic [W-1:0] rv;
    for (int c = 0; c < 2; c++) begin
      rv = rstv(c);
      for (int k = 0; k < 16; k++) m_chain[c][k] = (k < W*stg(c)) ? rv[k / stg(c)] : 1'b0;
      for (int i = 0; i < W; i++) begin
        m_qf[c][i]  = rv[i];
        m_qfd[c][i] = rv[i];
        m_run[c][i] = 0;
      end
    end
  endtask

  task automatic m_step();
    bit qold  [W];
    bit qfold [W];
    int s;
    for (int c = 0; c < 2; c++) begin
      s = stg(c);
      for (int i = 0; i < W; i++) begin
        qold[i]  = m_q(c, i);
        qfold[i] = m_qfo(c, i);
      end
      if (se_n) begin
        for (int i = 0; i < W; i++) begin
          m_qfd[c][i] = qfold[i];
          // QF follows Q only after FILT_CNT consecutive cycles of disagreement.
          if (flt(c) > 0) begin
            if (qold[i] == m_qf[c][i]) m_run[c][i] = 0;
            else begin
              m_run[c][i]++;
              if (m_run[c][i] == flt(c)) begin
                m_qf[c][i]  = qold[i];
                m_run[c][i] = 0;
              end
            end
          end
          for (int k = s - 1; k > 0; k--) m_chain[c][i*s+k] = m_chain[c][i*s+k-1];
          m_chain[c][i*s] = D[i];
        end
      end else begin
        for (int k = W*s - 1; k > 0; k--) m_chain[c][k] = m_chain[c][k-1];
        m_chain[c][0] = si;
      end
    end
  endtask

  function automatic logic [W-1:0] mvec(input int c, input int kind);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      case (kind)
        0:       v[i] = m_q(c, i);
        1:       v[i] = m_qfo(c, i);
        2:       v[i] = se_n &  m_qfo(c, i) & ~m_qfd[c][i];
        default: v[i] = se_n & ~m_qfo(c, i) &  m_qfd[c][i];
      endcase
    end
    return v;
  endfunction

  task automatic compare();
    check("q_filt",     32'(q0),  32'(mvec(0, 0)));
    check("qf_filt",    32'(qf0), 32'(mvec(0, 1)));
    check("rise_filt",  32'(r0),  32'(mvec(0, 2)));
    check("fall_filt",  32'(f0),  32'(mvec(0, 3)));
    check("so_filt",    32'(so0), 32'(m_chain[0][W*3-1]));
    check("q_byp",      32'(q1),  32'(mvec(1, 0)));
    check("qf_byp",     32'(qf1), 32'(mvec(1, 1)));
    check("rise_byp",   32'(r1),  32'(mvec(1, 2)));
    check("fall_byp",   32'(f1),  32'(mvec(1, 3)));
    check("so_byp",     32'(so1), 32'(m_chain[1][W*2-1]));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge CP);
    if (!CD) m_step();
    #1 compare();
    @(negedge CP);
  endtask

  task automatic hold(input logic [W-1:0] d, input int n);
    D = d;
    for (int k = 0; k < n; k++) cycle();
  endtask

  logic [11:0]  pat;
  logic [W-1:0] qf_before;
  int           lat0, lat1, cnt_f, qf_seen;
  int           hold_cnt [W];
  logic [7:0]   restart_seq;

  initial begin
    m_reset();
    @(negedge CP);
    #1 compare();
    // D toggling under reset must not leak through.
    for (int k = 0; k < 4; k++) begin
      D = (k % 2 == 0) ? 4'hF : 4'h0;
      cycle();
    end
    D  = 4'h0;
    CD = 1'b0;
    hold(4'h0, 12);

    // Latency: filtered ch0 rise after 7 edges, bypassed ch1 after 2.
    lat0 = -1; lat1 = -1;
    D = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (r0[0] && lat0 < 0) lat0 = k;
      if (r1[1] && lat1 < 0) lat1 = k;
    end
    check("lat_rise_filt", 32'(lat0), 32'd7);
    check("lat_rise_byp",  32'(lat1), 32'd2);

    // Glitch reject: 3-cycle pulse on ch1 never reaches QF, 4-cycle pulse does.
    hold(4'b0001, 12);
    qf_seen = 0;
    D = 4'b0011;
    for (int k = 0; k < 3; k++) begin cycle(); qf_seen |= int'(qf0[1]); end
    D = 4'b0001;
    for (int k = 0; k < 10; k++) begin cycle(); qf_seen |= int'(qf0[1]); end
    check("glitch3_qf", 32'(qf_seen), 32'd0);
    qf_seen = 0;
    hold(4'b0011, 4);
    D = 4'b0001;
    for (int k = 0; k < 12; k++) begin cycle(); qf_seen |= int'(qf0[1]); end
    check("pulse4_qf", 32'(qf_seen), 32'd1);

    // Filter restart on ch2: 1,1,1,0,1,1,1,1 rises only after the final run.
    restart_seq = 8'b1111_0111;
    lat0 = -1;
    for (int k = 0; k < 16; k++) begin
      D = (k < 8) ? {1'b0, restart_seq[k], 2'b01} : 4'b0101;
      cycle();
      if (r0[2] && lat0 < 0) lat0 = k + 1;
    end
    check("restart_lat", 32'(lat0), 32'd11);

    // Scan shift: pattern emerges on so after 12 edges, filter state held.
    qf_before = qf0;
    pat = 12'b1010_1100_0111;
    se_n = 1'b0;
    for (int k = 0; k < 24; k++) begin
      si = (k < 12) ? pat[11-k] : 1'b0;
      cycle();
      if (k >= 11 && k < 23) check("scan_so", 32'(so0), 32'(pat[11-(k-11)]));
    end
    check("scan_qf_hold", 32'(qf0), 32'(qf_before));
    se_n = 1'b1;
    si   = 1'b0;
    hold(4'h0, 14);

    // Simultaneous rise on all bypassed channels: RISE=F for exactly one cycle.
    cnt_f = 0;
    D = 4'hF;
    for (int k = 0; k < 8; k++) begin cycle(); if (r1 == 4'hF) cnt_f++; end
    check("byp_rise_all_once", 32'(cnt_f), 32'd1);

    // Randomised traffic with occasional scan bursts and one mid-run reset.
    for (int i = 0; i < W; i++) hold_cnt[i] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < W; i++) begin
        if (hold_cnt[i] == 0) begin
          D[i] = ~D[i];
          hold_cnt[i] = $urandom_range(1, 8);
        end
        hold_cnt[i]--;
      end
      if (se_n && ($urandom_range(0, 39) == 0)) se_n = 1'b0;
      else if (!se_n && ($urandom_range(0, 3) == 0)) se_n = 1'b1;
      si = 1'($urandom_range(0, 1));
      if (n == 300) begin
        CD = 1'b1;
        m_reset();
        #1 compare();
        cycle();
        CD = 1'b0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
